// File: rtl/ws2_vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan-out block.
package ws2_vga_pkg;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic   sof;
        rgb12_t rgb;
    } pix_word_t;

    typedef enum logic [1:0] {
        SEEK,
        WAIT,
        RUN
    } scan_state_e;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_FIFO_DEPTH = 1024;

    function automatic int span4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    localparam int H_TOTAL = span4(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = span4(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/ws2_sync_fifo.sv
// Single-clock show-ahead FIFO; RAM read is registered, with a bypass so a
// word written into an empty (or about-to-empty) FIFO is visible next clk.
module ws2_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [AW:0]      rd_ptr_next;
    logic [WIDTH-1:0] ram_q_reg;
    logic [WIDTH-1:0] bypass_reg;
    logic             bypass_sel_reg;
    logic             do_push;
    logic             do_pop;

    assign level       = wr_ptr_reg - rd_ptr_reg;
    assign full        = (level == (AW+1)'(DEPTH));
    assign empty       = (level == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Prefetch the word that will be at the head after this clk's pop.
    always_ff @(posedge clk) begin
        ram_q_reg <= mem[rd_ptr_next[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            bypass_reg     <= '0;
            bypass_sel_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg     <= rd_ptr_next;
            bypass_sel_reg <= do_push && (wr_ptr_reg == rd_ptr_next);
            bypass_reg     <= push_data;
        end
    end

    assign head = bypass_sel_reg ? bypass_reg : ram_q_reg;

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator that aligns a buffered RGB444 stream to the frame
// using its SOF marker and self-recovers from underflow or misalignment.
module vga_scanout
    import ws2_vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [11:0]                   s_data,
    input  logic                          s_sof,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          clr_status,
    output logic                          underflow,
    output logic                          resync,
    output logic                          frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [3:0]                    vga_red,
    output logic [3:0]                    vga_green,
    output logic [3:0]                    vga_blue,
    output logic                          vga_hs,
    output logic                          vga_vs
);

    localparam int LINE_LEN    = span4(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int FRAME_LINES = span4(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW          = $clog2(LINE_LEN);
    localparam int VW          = $clog2(FRAME_LINES);
    localparam int WORD_W      = $bits(pix_word_t);

    localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(FRAME_LINES - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    scan_state_e     state_reg;
    scan_state_e     state_next;
    logic            pix_en_reg;
    logic [HW-1:0]   h_reg;
    logic [VW-1:0]   v_reg;
    rgb12_t          rgb_reg;
    logic            hs_reg;
    logic            vs_reg;
    logic            frame_start_reg;
    logic            underflow_reg;
    logic            resync_reg;

    logic            active;
    logic            at_origin;
    logic            hs_zone;
    logic            vs_zone;
    logic            pop;
    rgb12_t          pix_rgb;
    logic            frame_start_evt;
    logic            underflow_evt;
    logic            resync_evt;

    logic            fifo_full;
    logic            fifo_empty;
    logic [WORD_W-1:0] head_bits;
    pix_word_t       head_word;
    pix_word_t       push_word;

    assign push_word = '{sof: s_sof, rgb: s_data};
    assign head_word = pix_word_t'(head_bits);
    assign s_ready   = !fifo_full;

    ws2_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s_valid && s_ready),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign active    = (h_reg < H_ACT) && (v_reg < V_ACT);
    assign at_origin = (h_reg == '0) && (v_reg == '0);
    assign hs_zone   = (h_reg >= HS_FIRST) && (h_reg <= HS_LAST);
    assign vs_zone   = (v_reg >= VS_FIRST) && (v_reg <= VS_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en_reg <= 1'b0;
            h_reg      <= '0;
            v_reg      <= '0;
        end else begin
            pix_en_reg <= ~pix_en_reg;
            if (pix_en_reg) begin
                if (h_reg == H_LAST) begin
                    h_reg <= '0;
                    v_reg <= (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
                end else begin
                    h_reg <= h_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= SEEK;
        end else begin
            state_reg <= state_next;
        end
    end

    // WAIT is only entered with an SOF word at the head, and nothing pops
    // there, so the head is guaranteed valid when (0,0) arrives.
    always_comb begin
        state_next      = state_reg;
        pop             = 1'b0;
        pix_rgb         = '0;
        frame_start_evt = 1'b0;
        underflow_evt   = 1'b0;
        resync_evt      = 1'b0;
        case (state_reg)
            SEEK: begin
                if (!fifo_empty) begin
                    if (head_word.sof) begin
                        state_next = WAIT;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (pix_en_reg && at_origin) begin
                    state_next      = RUN;
                    pop             = 1'b1;
                    pix_rgb         = head_word.rgb;
                    frame_start_evt = 1'b1;
                end
            end
            RUN: begin
                if (pix_en_reg && active) begin
                    if (fifo_empty) begin
                        underflow_evt = 1'b1;
                        state_next    = SEEK;
                    end else if (head_word.sof && !at_origin) begin
                        resync_evt = 1'b1;
                        state_next = WAIT;
                    end else begin
                        pop             = 1'b1;
                        pix_rgb         = head_word.rgb;
                        frame_start_evt = at_origin;
                    end
                end
            end
            default: begin
                state_next = SEEK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_reg         <= '0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
            resync_reg      <= 1'b0;
        end else begin
            if (pix_en_reg) begin
                rgb_reg <= pix_rgb;
                hs_reg  <= !hs_zone;
                vs_reg  <= !vs_zone;
            end
            frame_start_reg <= frame_start_evt;
            // A new event wins over a simultaneous clear.
            if (underflow_evt) begin
                underflow_reg <= 1'b1;
            end else if (clr_status) begin
                underflow_reg <= 1'b0;
            end
            if (resync_evt) begin
                resync_reg <= 1'b1;
            end else if (clr_status) begin
                resync_reg <= 1'b0;
            end
        end
    end

    assign vga_red     = rgb_reg[11:8];
    assign vga_green   = rgb_reg[7:4];
    assign vga_blue    = rgb_reg[3:0];
    assign vga_hs      = hs_reg;
    assign vga_vs      = vs_reg;
    assign frame_start = frame_start_reg;
    assign underflow   = underflow_reg;
    assign resync      = resync_reg;

endmodule
